// File: rtl/mem_wb_stage.sv
// Stage 4 of the pipeline: data memory access, branch resolution and the
// MEM/WB register that feeds the register file write port.
module mem_wb_stage #(
    parameter int unsigned DEPTH_BYTES = 512,
    parameter int unsigned LATENCY     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Result_MEM,
    input  logic [63:0] Read_Data_2_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic        Branch_MEM,
    input  logic        Zero_MEM,
    input  logic        MemWrite_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemtoReg_MEM,
    input  logic        RegWrite_MEM,
    input  logic [63:0] Branch_Adder_Out_MEM,
    output logic        to_branch,
    output logic [63:0] Branch_Target,
    output logic        stall,
    output logic        misaligned,
    output logic [4:0]  rd_WB,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic [63:0] Result_WB,
    output logic [63:0] Read_Data_WB,
    output logic [63:0] MUX5_Out
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_BYTES);
    localparam int unsigned IDX_W  = ADDR_W - 3;
    localparam int unsigned WORDS  = DEPTH_BYTES / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    logic [63:0]      r_mem [WORDS];
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_access;
    logic             w_commit;
    logic             w_stall;
    logic [IDX_W-1:0] w_idx;
    logic [63:0]      w_rdata;

    // Doubleword index: low 3 bits dropped, bits above the memory size ignored
    assign w_access = MemRead_MEM | MemWrite_MEM;
    assign w_idx    = Result_MEM[ADDR_W-1:3];
    assign w_rdata  = r_mem[w_idx];

    // Combinational stage outputs
    assign to_branch     = Branch_MEM & Zero_MEM;
    assign Branch_Target = Branch_Adder_Out_MEM;
    assign misaligned    = w_access & (Result_MEM[2:0] != 3'b000);
    assign stall         = w_stall;
    assign MUX5_Out      = MemtoReg_WB ? Read_Data_WB : Result_WB;

    // Wait-state FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, stall and commit; with LATENCY=0 every cycle commits
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_commit    = 1'b1;
        if (LATENCY != 0) begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        w_stall     = 1'b1;
                        w_commit    = 1'b0;
                        w_cnt_nxt   = CNT_W'(LATENCY - 1);
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        w_stall   = 1'b1;
                        w_commit  = 1'b0;
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Data memory store port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit && MemWrite_MEM) begin
            r_mem[w_idx] <= Read_Data_2_MEM;
        end
    end

    // MEM/WB register: capture on commit, bubble while the access is pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_WB        <= '0;
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            Result_WB    <= '0;
            Read_Data_WB <= '0;
        end else if (w_commit) begin
            rd_WB        <= rd_MEM;
            RegWrite_WB  <= RegWrite_MEM;
            MemtoReg_WB  <= MemtoReg_MEM;
            Result_WB    <= Result_MEM;
            Read_Data_WB <= w_rdata;
        end else begin
            rd_WB        <= '0;
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            Result_WB    <= '0;
            Read_Data_WB <= '0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: one single-cycle instance and one LATENCY=3
// instance, random traffic against a doubleword-array reference model.
module tb_mem_wb_stage;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        m2r;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [63:0] res [2];
    logic [63:0] wd  [2];
    logic [63:0] tgt [2];
    logic [4:0]  rd  [2];
    logic        br  [2];
    logic        z   [2];
    logic        mw  [2];
    logic        mr  [2];
    logic        m2r [2];
    logic        rw  [2];

    logic        to_br0, stall0, mis0, rwwb0, m2rwb0;
    logic        to_br1, stall1, mis1, rwwb1, m2rwb1;
    logic [63:0] btgt0, reswb0, rdatwb0, mux0;
    logic [63:0] btgt1, reswb1, rdatwb1, mux1;
    logic [4:0]  rdwb0, rdwb1;

    logic [63:0] mdl [2][64];
    exp_t        q0[$];
    exp_t        q1[$];

    mem_wb_stage #(.DEPTH_BYTES(512), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .Result_MEM(res[0]), .Read_Data_2_MEM(wd[0]), .rd_MEM(rd[0]),
        .Branch_MEM(br[0]), .Zero_MEM(z[0]), .MemWrite_MEM(mw[0]),
        .MemRead_MEM(mr[0]), .MemtoReg_MEM(m2r[0]), .RegWrite_MEM(rw[0]),
        .Branch_Adder_Out_MEM(tgt[0]),
        .to_branch(to_br0), .Branch_Target(btgt0), .stall(stall0),
        .misaligned(mis0), .rd_WB(rdwb0), .RegWrite_WB(rwwb0),
        .MemtoReg_WB(m2rwb0), .Result_WB(reswb0), .Read_Data_WB(rdatwb0),
        .MUX5_Out(mux0)
    );

    mem_wb_stage #(.DEPTH_BYTES(512), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .Result_MEM(res[1]), .Read_Data_2_MEM(wd[1]), .rd_MEM(rd[1]),
        .Branch_MEM(br[1]), .Zero_MEM(z[1]), .MemWrite_MEM(mw[1]),
        .MemRead_MEM(mr[1]), .MemtoReg_MEM(m2r[1]), .RegWrite_MEM(rw[1]),
        .Branch_Adder_Out_MEM(tgt[1]),
        .to_branch(to_br1), .Branch_Target(btgt1), .stall(stall1),
        .misaligned(mis1), .rd_WB(rdwb1), .RegWrite_WB(rwwb1),
        .MemtoReg_WB(m2rwb1), .Result_WB(reswb1), .Read_Data_WB(rdatwb1),
        .MUX5_Out(mux1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h required %h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: pop one expectation per presented write-back
    task automatic mon(input int d, input logic [4:0] r, input logic [63:0] m, input logic mm);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected dut%0d @cyc %0d: got rd=%0d data=%h, required no write-back",
                     d, cyc, r, m);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("wb_cycle dut%0d", d), 64'(cyc), 64'(e.cyc));
            chk($sformatf("wb_rd dut%0d", d), 64'(r), 64'(e.rd));
            chk($sformatf("wb_data dut%0d", d), m, e.data);
            chk($sformatf("wb_memtoreg dut%0d", d), 64'(mm), 64'(e.m2r));
        end
    endtask

    always @(negedge clk) if (reset && rwwb0) mon(0, rdwb0, mux0, m2rwb0);
    always @(negedge clk) if (reset && rwwb1) mon(1, rdwb1, mux1, m2rwb1);

    task automatic nop_in(input int d);
        res[d] = '0; wd[d] = '0; tgt[d] = '0; rd[d] = '0;
        br[d] = 1'b0; z[d] = 1'b0; mw[d] = 1'b0; mr[d] = 1'b0;
        m2r[d] = 1'b0; rw[d] = 1'b0;
    endtask

    // Issue one instruction, hold it through any wait cycles, update the model
    task automatic op(input int d, input logic [63:0] a, input logic [63:0] w,
                      input logic [4:0] r, input logic b, input logic zz,
                      input logic st, input logic ld, input logic sel,
                      input logic we, input logic [63:0] t);
        int          n;
        logic [5:0]  idx;
        logic [63:0] old;
        exp_t        e;
        res[d] = a; wd[d] = w; rd[d] = r; br[d] = b; z[d] = zz;
        mw[d] = st; mr[d] = ld; m2r[d] = sel; rw[d] = we; tgt[d] = t;
        n   = (d == 1 && (st || ld)) ? 3 : 0;
        idx = a[8:3];
        old = mdl[d][idx];
        if (we) begin
            e.cyc = cyc + n + 1; e.rd = r; e.m2r = sel;
            e.data = sel ? old : a;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        #1;
        chk("to_branch", 64'((d == 0) ? to_br0 : to_br1), 64'(b & zz));
        chk("branch_target", (d == 0) ? btgt0 : btgt1, t);
        chk("misaligned", 64'((d == 0) ? mis0 : mis1), 64'((st | ld) && (a[2:0] != 3'b000)));
        for (int i = 0; i <= n; i++) begin
            chk($sformatf("stall dut%0d cycle%0d", d, i), 64'((d == 0) ? stall0 : stall1), 64'(i < n));
            if (i > 0) chk("bubble_regwrite", 64'(rwwb1), 64'(0));
            @(posedge clk);
            #1;
        end
        if (st) mdl[d][idx] = w;
        nop_in(d);
    endtask

    task automatic chk_wb_zero(input int d);
        if (d == 0) begin
            chk("rst_rd_WB0", 64'(rdwb0), 64'(0));   chk("rst_RegWrite_WB0", 64'(rwwb0), 64'(0));
            chk("rst_MemtoReg_WB0", 64'(m2rwb0), 64'(0)); chk("rst_Result_WB0", reswb0, 64'(0));
            chk("rst_Read_Data_WB0", rdatwb0, 64'(0)); chk("rst_stall0", 64'(stall0), 64'(0));
        end else begin
            chk("rst_rd_WB1", 64'(rdwb1), 64'(0));   chk("rst_RegWrite_WB1", 64'(rwwb1), 64'(0));
            chk("rst_MemtoReg_WB1", 64'(m2rwb1), 64'(0)); chk("rst_Result_WB1", reswb1, 64'(0));
            chk("rst_Read_Data_WB1", rdatwb1, 64'(0)); chk("rst_stall1", 64'(stall1), 64'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, w, t;
        logic [4:0]  r;
        logic        b, zz, st, ld, sel, we;
        int          kind, d;

        for (int k = 0; k < 2; k++) for (int j = 0; j < 64; j++) mdl[k][j] = '0;
        nop_in(0);
        nop_in(1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_wb_zero(0);
        chk_wb_zero(1);
        reset = 1'b1;

        // Bring both memories to a known all-zero image
        for (int j = 0; j < 64; j++) op(0, 64'(j * 8), '0, '0, 0, 0, 1, 0, 0, 0, '0);
        for (int j = 0; j < 64; j++) op(1, 64'(j * 8), '0, '0, 0, 0, 1, 0, 0, 0, '0);

        // Store then load back-to-back, single-cycle memory
        op(0, 64'h10, 64'hDEADBEEF_01234567, 5'd0, 0, 0, 1, 0, 0, 0, '0);
        op(0, 64'h10, '0, 5'd5, 0, 0, 0, 1, 1, 1, '0);
        chk("load_data_direct", mux0, 64'hDEADBEEF_01234567);
        chk("load_rd_direct", 64'(rdwb0), 64'(5));
        chk("load_regwrite_direct", 64'(rwwb0), 64'(1));

        // ALU pass-through
        op(0, 64'd42, '0, 5'd3, 0, 0, 0, 0, 0, 1, '0);
        chk("alu_data_direct", mux0, 64'd42);
        chk("alu_rd_direct", 64'(rdwb0), 64'(3));

        // Branch taken / not taken
        op(0, '0, '0, '0, 1, 1, 0, 0, 0, 0, 64'h80);
        op(0, '0, '0, '0, 1, 0, 0, 0, 0, 0, 64'h80);

        // Misaligned store lands on the aligned doubleword
        op(0, 64'h13, 64'hCAFE_F00D_1234_5678, '0, 0, 0, 1, 0, 0, 0, '0);
        op(0, 64'h10, '0, 5'd6, 0, 0, 0, 1, 1, 1, '0);
        chk("misalign_data_direct", mux0, 64'hCAFE_F00D_1234_5678);

        // Latency and address wrap: 0x208 aliases 0x008
        op(1, 64'h8, 64'h0123_4567_89AB_CDEF, '0, 0, 0, 1, 0, 0, 0, '0);
        op(1, 64'h208, '0, 5'd7, 0, 0, 0, 1, 1, 1, '0);
        chk("wrap_data_direct", mux1, 64'h0123_4567_89AB_CDEF);
        op(1, 64'd99, '0, 5'd2, 0, 0, 0, 0, 0, 1, '0);

        // Reset in the 2nd stall cycle discards the pending store
        op(1, 64'h40, 64'h1111_2222_3333_4444, '0, 0, 0, 1, 0, 0, 0, '0);
        res[1] = 64'h40; wd[1] = 64'hBAD0_BAD0_BAD0_BAD0; mw[1] = 1'b1;
        #1;
        chk("abort_stall_c0", 64'(stall1), 64'(1));
        @(posedge clk);
        #1;
        chk("abort_stall_c1", 64'(stall1), 64'(1));
        reset = 1'b0;
        nop_in(1);
        #1;
        chk_wb_zero(1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        op(1, 64'h40, '0, 5'd9, 0, 0, 0, 1, 1, 1, '0);
        chk("abort_mem_kept", mux1, 64'h1111_2222_3333_4444);

        // Mid-run reset keeps memory contents
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_wb_zero(0);
        chk_wb_zero(1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        op(0, 64'h10, '0, 5'd4, 0, 0, 0, 1, 1, 1, '0);
        chk("reset_mem_kept", mux0, 64'hCAFE_F00D_1234_5678);

        // Random traffic on both instances
        for (int k = 0; k < 300; k++) begin
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 4));
            a    = {$urandom(), $urandom()};
            w    = {$urandom(), $urandom()};
            t    = {$urandom(), $urandom()};
            r    = 5'($urandom_range(0, 31));
            zz   = 1'($urandom_range(0, 1));
            b = 0; st = 0; ld = 0; sel = 0; we = 0;
            case (kind)
                0:       we = 1;
                1:       begin ld = 1; sel = 1; we = 1; end
                2:       st = 1;
                3:       b = 1;
                default: begin st = 1; ld = 1; sel = 1; we = 1; end
            endcase
            op(d, a, w, r, b, zz, st, ld, sel, we, t);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained0", 64'(q0.size()), 64'(0));
        chk("scoreboard_drained1", 64'(q1.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage 4 plus the MEM/WB register; consumes the EX_MEM outputs and feeds the register file write port.
- Contains the byte-addressable data memory and resolves branches (to_branch, branch target) for the PC mux.
- Produces the write-back value for the register file (rd_WB, MUX5_Out, RegWrite_WB).
- Can model a multi-cycle data memory and raise a stall while an access is outstanding.

Parameters:
DEPTH_BYTES, 512, data memory size in bytes; power of two, multiple of 8
LATENCY, 0, extra wait cycles per load/store; 0 means single-cycle memory, maximum 15

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
Result_MEM  input  64  ALU result; memory byte address or write-back data
Read_Data_2_MEM  input  64  store data
rd_MEM  input  5  destination register
Branch_MEM  input  1  branch instruction
Zero_MEM  input  1  ALU zero flag
MemWrite_MEM  input  1  store
MemRead_MEM  input  1  load
MemtoReg_MEM  input  1  write-back selects memory data
RegWrite_MEM  input  1  register write enable
Branch_Adder_Out_MEM  input  64  branch target
to_branch  output  1  taken-branch select for the PC mux
Branch_Target  output  64  PC value when to_branch=1
stall  output  1  upstream stages and EX_MEM must hold
misaligned  output  1  memory access with Result_MEM[2:0] != 0
rd_WB  output  5  registered destination register
RegWrite_WB  output  1  registered write enable
MemtoReg_WB  output  1  registered write-back select
Result_WB  output  64  registered ALU result
Read_Data_WB  output  64  registered load data
MUX5_Out  output  64  write-back data

Behaviour:
- Reset (reset=0, asynchronous):
  - rd_WB=0, RegWrite_WB=0, MemtoReg_WB=0, Result_WB=0, Read_Data_WB=0.
  - FSM goes to IDLE; wait counter cleared.
  - Data memory contents are not affected by reset; simulation initialises them to 0.
- Combinational outputs:
  - to_branch = Branch_MEM & Zero_MEM.
  - Branch_Target = Branch_Adder_Out_MEM.
  - MUX5_Out = MemtoReg_WB ? Read_Data_WB : Result_WB.
  - misaligned = (MemRead_MEM | MemWrite_MEM) & (Result_MEM[2:0] != 0).
- Memory addressing:
  - Little-endian; each access is one aligned doubleword.
  - Byte index = {Result_MEM[log2(DEPTH_BYTES)-1:3], 3'b000]}; upper address bits are ignored, so addresses wrap modulo DEPTH_BYTES.
  - Misaligned accesses are still performed with the low 3 bits forced to 0.
- Loads: load data is read combinationally at the selected address.
- Stores: memory is written at the rising edge that completes the access.
- Store then load, same address, back-to-back: the load returns the stored value.
- MemRead_MEM and MemWrite_MEM both high: treated as a store; load data is still captured (old contents).
- FSM with LATENCY=0:
  - No state is used; stall=0 always.
  - MEM/WB captures the stage-4 values at every edge; load-use latency is 1 cycle into WB.
- FSM with LATENCY=N>0, states IDLE and WAIT:
  - IDLE, access present (MemRead_MEM|MemWrite_MEM): stall=1 combinationally; counter loads N-1; next state WAIT. No write; MEM/WB loads a bubble (RegWrite_WB=0, other fields zero).
  - WAIT, counter != 0: stall=1; counter decrements; bubble into MEM/WB.
  - WAIT, counter == 0: stall=0. At the edge: store committed, MEM/WB captures load data and controls, next state IDLE.
  - stall is therefore high for exactly N cycles per access.
  - Upstream holds the EX_MEM outputs stable while stall=1; the inputs are sampled only in the completing cycle.
  - Non-memory instructions in IDLE pass through with no stall.
  - Back-to-back memory ops each incur the full N-cycle stall.
- Reset during WAIT: FSM returns to IDLE and the pending store is discarded (memory unchanged).
- Branch: to_branch is independent of stall; a branch is never a memory op, so the two cannot coincide.

Test Plan:
- Reset: hold reset=0 mid-run, then release → all WB outputs read 0, stall=0, and memory keeps prior data.
- Store/load, LATENCY=0: store 64'hDEADBEEF_01234567 at Result_MEM=0x10; next cycle load 0x10 with MemtoReg=1, rd=5 → one cycle later rd_WB=5, RegWrite_WB=1, MUX5_Out=64'hDEADBEEF_01234567.
- ALU pass-through: Result_MEM=42, RegWrite=1, MemtoReg=0, rd=3 → next cycle MUX5_Out=42, rd_WB=3, and memory is untouched.
- Branch: Branch=1, Zero=1, target 0x80 → to_branch=1, Branch_Target=0x80 in the same cycle; with Zero=0 → to_branch=0.
- Latency and wrap, LATENCY=3: load at address 0x208 with DEPTH_BYTES=512 → stall high for 3 cycles with RegWrite_WB=0 each cycle, data comes from byte 0x008, WB valid on the 4th edge, misaligned=0.
- Misalign and reset abort:
  - Store to 0x13 → misaligned=1 and the write lands at 0x10.
  - LATENCY=3 store with reset asserted in the 2nd stall cycle → target doubleword keeps its old value and FSM is IDLE.
